// File: rtl/alarm_pkg.sv
// ----------------------------------------------------------------------------
// alarm_pkg
// Shared types, default timing constants and width helpers for the
// multi-zone alarm controller.
//   state_t    : controller state encoding
//   cnt_width  : bits needed to hold 0..max_val (at least 1)
//   max2       : larger of two integers, used for shared counters
// ----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_t;

    localparam int DEF_N_ZONES        = 4;
    localparam int DEF_CLK_PER_TICK   = 25000;
    localparam int DEF_DEBOUNCE_TICKS = 20;
    localparam int DEF_EXIT_TICKS     = 30000;
    localparam int DEF_ENTRY_TICKS    = 15000;
    localparam int DEF_SIREN_TICKS    = 250;
    localparam int DEF_ALARM_TICKS    = 180000;
    localparam int DEF_BLINK_TICKS    = 500;

    function automatic int cnt_width(input int max_val);
        if (max_val < 1) return 1;
        return $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_controller_zone_debounce.sv
// ----------------------------------------------------------------------------
// zone_debounce
// Conditions one raw sensor zone: 2-FF synchroniser, polarity correction and
// a tick-based stability counter. The accepted level only follows the
// corrected input after it has differed for DEBOUNCE_TICKS consecutive ticks.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : timebase strobe (one clk wide)
//   raw        : asynchronous sensor pin
//   level      : debounced, active-high zone state (0 = quiet)
// ----------------------------------------------------------------------------
module zone_debounce
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int CW = cnt_width(DEBOUNCE_TICKS);

    logic          sync1;
    logic          sync2;
    logic          asserted;
    logic [CW-1:0] stable_cnt;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, which is what makes
    // the two-stage synchroniser a real two-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign asserted = sync2 ^ ACTIVE_LOW;

    // The counter only runs while the input disagrees with the accepted
    // level; any return to agreement restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (asserted == level) begin
            stable_cnt <= '0;
        end else if (tick) begin
            if (int'(stable_cnt) + 1 >= DEBOUNCE_TICKS) begin
                level      <= asserted;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// ----------------------------------------------------------------------------
// alarm_controller
// Multi-zone arm/exit/entry/alarm controller. Conditions the arm switch,
// disarm key and N sensor zones, runs the state machine and drives the
// status LED, siren and a one-shot notifier pulse.
// Build option: define ALARM_CTRL_TAMPER_EN to add a tamper input that forces
// ALARM from any state (overriding the disarm key).
//   clk, rst_n : clock, asynchronous active-low reset
//   sw_on      : raw arm switch
//   zone_in    : raw sensor inputs, polarity set by ACTIVE_LOW_MASK
//   clave      : raw disarm key, rising edge = valid code
//   tamper     : raw tamper loop (only with ALARM_CTRL_TAMPER_EN)
//   led        : status indicator
//   sound      : siren drive
//   mensaje    : one-clk pulse when ALARM is entered
//   alarm_zone : sticky record of zones that contributed to the alarm
// ----------------------------------------------------------------------------
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int          N_ZONES         = DEF_N_ZONES,
    parameter int          CLK_PER_TICK    = DEF_CLK_PER_TICK,
    parameter int          DEBOUNCE_TICKS  = DEF_DEBOUNCE_TICKS,
    parameter int          EXIT_TICKS      = DEF_EXIT_TICKS,
    parameter int          ENTRY_TICKS     = DEF_ENTRY_TICKS,
    parameter int          SIREN_TICKS     = DEF_SIREN_TICKS,
    parameter int          ALARM_TICKS     = DEF_ALARM_TICKS,
    parameter int          BLINK_TICKS     = DEF_BLINK_TICKS,
    parameter logic [15:0] ACTIVE_LOW_MASK = 16'h0000,
    parameter logic [15:0] INSTANT_MASK    = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_on,
    input  logic [N_ZONES-1:0] zone_in,
    input  logic               clave,
`ifdef ALARM_CTRL_TAMPER_EN
    input  logic               tamper,
`endif
    output logic               led,
    output logic               sound,
    output logic               mensaje,
    output logic [N_ZONES-1:0] alarm_zone
);

    localparam int TCW = cnt_width(CLK_PER_TICK - 1);
    localparam int TW  = cnt_width(max2(EXIT_TICKS, ENTRY_TICKS));
    localparam int SW  = cnt_width(ALARM_TICKS);
    localparam int PW  = cnt_width(max2(SIREN_TICKS, BLINK_TICKS));

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [TCW-1:0] tick_cnt;
    logic           tick;

    assign tick = (tick_cnt == TCW'(CLK_PER_TICK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Switch / key conditioning. The edge pulses are registered, so the
    // FSM reacts on the fourth clk edge after a raw edge; the level of
    // sw_on is taken from the same delayed stage to stay aligned.
    // ------------------------------------------------------------------
    logic sw_s1, sw_s2, sw_d, sw_rise;
    logic clave_s1, clave_s2, clave_d, clave_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1      <= 1'b0;
            sw_s2      <= 1'b0;
            sw_d       <= 1'b0;
            sw_rise    <= 1'b0;
            clave_s1   <= 1'b0;
            clave_s2   <= 1'b0;
            clave_d    <= 1'b0;
            clave_rise <= 1'b0;
        end else begin
            sw_s1      <= sw_on;
            sw_s2      <= sw_s1;
            sw_d       <= sw_s2;
            sw_rise    <= sw_s2 & ~sw_d;
            clave_s1   <= clave;
            clave_s2   <= clave_s1;
            clave_d    <= clave_s2;
            clave_rise <= clave_s2 & ~clave_d;
        end
    end

    logic tamper_trip;
`ifdef ALARM_CTRL_TAMPER_EN
    logic tamper_s1, tamper_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tamper_s1 <= 1'b0;
            tamper_s2 <= 1'b0;
        end else begin
            tamper_s1 <= tamper;
            tamper_s2 <= tamper_s1;
        end
    end

    assign tamper_trip = tamper_s2;
`else
    assign tamper_trip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Zone conditioning
    // ------------------------------------------------------------------
    logic [N_ZONES-1:0] zone_lvl;
    logic               inst_act;
    logic               del_act;

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        zone_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .ACTIVE_LOW    (ACTIVE_LOW_MASK[i])
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .raw  (zone_in[i]),
            .level(zone_lvl[i])
        );
    end

    assign inst_act = |(zone_lvl &  INSTANT_MASK[N_ZONES-1:0]);
    assign del_act  = |(zone_lvl & ~INSTANT_MASK[N_ZONES-1:0]);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t             state_q, prev_q, state_next;
    logic [TW-1:0]      timer_q;
    logic [SW-1:0]      siren_q;
    logic [PW-1:0]      phase_q;
    logic               blink_q;
    logic [N_ZONES-1:0] zone_acc;
    logic               timer_done;
    logic               phase_wrap;
    int                 half_period;

    // A delay of N ticks expires on its Nth tick; a zero delay on the first.
    assign timer_done  = tick && (timer_q <= TW'(1));
    assign half_period = (state_q == ALARM) ? SIREN_TICKS : BLINK_TICKS;
    assign phase_wrap  = (int'(phase_q) + 1 >= half_period);

    // NOTE: state_next gets a default before the case so that every path
    // assigns it; a missing default would infer a latch.
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            DISARMED: begin
                if (sw_rise) state_next = EXIT_DELAY;
            end
            EXIT_DELAY: begin
                if (clave_rise || !sw_d) state_next = DISARMED;
                else if (timer_done)     state_next = ARMED;
            end
            ARMED: begin
                if (clave_rise)    state_next = DISARMED;
                else if (inst_act) state_next = ALARM;
                else if (del_act)  state_next = ENTRY_DELAY;
            end
            ENTRY_DELAY: begin
                if (clave_rise)                  state_next = DISARMED;
                else if (inst_act || timer_done) state_next = ALARM;
            end
            ALARM: begin
                if (clave_rise) state_next = DISARMED;
            end
            default: state_next = DISARMED;
        endcase
        if (tamper_trip) state_next = ALARM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISARMED;
            prev_q     <= DISARMED;
            timer_q    <= '0;
            siren_q    <= '0;
            phase_q    <= '0;
            blink_q    <= 1'b0;
            zone_acc   <= '0;
            led        <= 1'b0;
            sound      <= 1'b0;
            mensaje    <= 1'b0;
            alarm_zone <= '0;
        end else begin
            state_q <= state_next;
            prev_q  <= state_q;

            // Every state entry restarts the delay timer and the blink phase.
            if (state_next != state_q) begin
                phase_q <= '0;
                blink_q <= 1'b1;
                case (state_next)
                    EXIT_DELAY:  timer_q <= TW'(EXIT_TICKS);
                    ENTRY_DELAY: timer_q <= TW'(ENTRY_TICKS);
                    default:     timer_q <= '0;
                endcase
                if (state_next == ALARM) siren_q <= SW'(ALARM_TICKS);
            end else if (tick) begin
                if (timer_q != '0) timer_q <= timer_q - 1'b1;
                if ((state_q == ALARM && siren_q != '0) ||
                    state_q == EXIT_DELAY || state_q == ENTRY_DELAY) begin
                    if (phase_wrap) begin
                        phase_q <= '0;
                        blink_q <= ~blink_q;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                if (state_q == ALARM && siren_q != '0) siren_q <= siren_q - 1'b1;
            end

            // Zone record: cleared on disarm, accumulated on every ALARM
            // cycle except those forced by tamper.
            if (state_next == DISARMED)
                zone_acc <= '0;
            else if (state_next == ALARM && !tamper_trip)
                zone_acc <= zone_acc | zone_lvl;

            // Registered outputs, derived from the current state.
            mensaje    <= (state_q == ALARM) && (prev_q != ALARM);
            alarm_zone <= zone_acc;
            case (state_q)
                EXIT_DELAY, ENTRY_DELAY: begin
                    led   <= blink_q;
                    sound <= 1'b0;
                end
                ARMED: begin
                    led   <= 1'b1;
                    sound <= 1'b0;
                end
                ALARM: begin
                    led   <= (siren_q != '0) ? blink_q : 1'b1;
                    sound <= (siren_q != '0) ? blink_q : 1'b0;
                end
                default: begin
                    led   <= 1'b0;
                    sound <= 1'b0;
                end
            endcase
        end
    end

endmodule
